// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci term BCD converter: default widths,
// FIFO entry layout, conversion FSM states and the double-dabble digit step.
package fib_pkg;

  localparam int IN_W_DEF  = 6;
  localparam int CNT_W_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam int DIGIT_W   = 4;

  // FIFO entry layout, LSB first: ones digit, tens digit, term index, restart flag.
  localparam int ONES_LSB  = 0;
  localparam int TENS_LSB  = DIGIT_W;
  localparam int INDEX_LSB = 2 * DIGIT_W;

  function automatic int restart_pos(int cnt_w);
    return INDEX_LSB + cnt_w;
  endfunction

  function automatic int entry_w(int cnt_w);
    return INDEX_LSB + cnt_w + 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // One double-dabble correction: a digit of 5 or more would carry wrongly
  // after the next doubling, so bias it by 3 first.
  function automatic logic [DIGIT_W-1:0] bcd_adjust(logic [DIGIT_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/fib_sync_fifo.sv
// Small synchronous FIFO. A push into a full FIFO is accepted only when a pop
// happens on the same edge; otherwise the push is discarded (caller flags it).
module fib_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // Storage array: written on accepted pushes only.
  // NOTE: the data array is deliberately left out of reset; only the pointers
  // and count decide validity, so resetting it would only cost flops.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fib_term_bcd.sv
// Converts incoming Fibonacci terms to two BCD digits with a sequential
// double-dabble engine, tags them with index/restart and queues the results.
module fib_term_bcd
  import fib_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IN_W-1:0]  term,
  input  logic             in_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_tens,
  output logic [3:0]       out_ones,
  output logic [CNT_W-1:0] out_index,
  output logic             out_restart,
  output logic             overflow,
  output logic             busy
);

  localparam int SR_W      = 2 * DIGIT_W + IN_W;
  localparam int ITER_W    = $clog2(IN_W + 1);
  localparam int ENTRY_W   = entry_w(CNT_W);
  localparam int RESTART_B = restart_pos(CNT_W);

  state_t             state, state_next;
  logic [SR_W-1:0]    sr;
  logic [SR_W-1:0]    sr_adj;
  logic [SR_W-1:0]    sr_shift;
  logic [ITER_W-1:0]  iter;
  logic [CNT_W-1:0]   cnt;
  logic [IN_W-1:0]    prev_term;
  logic               cur_restart;
  logic [CNT_W-1:0]   cur_index;
  logic               start_restart;
  logic [CNT_W-1:0]   start_index;
  logic               accept;
  logic               done;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               push_drop;

  assign accept        = (state == ST_IDLE) && in_valid;
  assign done          = (state == ST_CONV) && (iter == ITER_W'(IN_W - 1));
  assign start_restart = (term < prev_term);
  assign start_index   = start_restart ? '0 : cnt;

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next state and busy flag.
  // NOTE: every output of a combinational block gets a default first so no
  // path through it can leave a value held, which would infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      ST_IDLE: if (in_valid) state_next = ST_CONV;
      ST_CONV: begin
        busy = 1'b1;
        if (done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One double-dabble step: correct both BCD digits, then shift the whole register.
  always_comb begin
    sr_adj = sr;
    sr_adj[SR_W-1 -: DIGIT_W]         = bcd_adjust(sr[SR_W-1 -: DIGIT_W]);
    sr_adj[SR_W-1-DIGIT_W -: DIGIT_W] = bcd_adjust(sr[SR_W-1-DIGIT_W -: DIGIT_W]);
    sr_shift = sr_adj << 1;
  end

  // Conversion datapath, term index counter and previous-term tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr          <= '0;
      iter        <= '0;
      cnt         <= '0;
      prev_term   <= '0;
      cur_restart <= 1'b0;
      cur_index   <= '0;
    end else if (accept) begin
      sr          <= {{(2*DIGIT_W){1'b0}}, term};
      iter        <= '0;
      cur_restart <= start_restart;
      cur_index   <= start_index;
      cnt         <= start_index + CNT_W'(1);
      prev_term   <= term;
    end else if (state == ST_CONV) begin
      sr   <= sr_shift;
      iter <= iter + ITER_W'(1);
    end
  end

  // The final step's shifted value is pushed directly, so no extra state is needed.
  assign push_data = {cur_restart, cur_index, sr_shift[SR_W-1 -: 2*DIGIT_W]};
  assign fifo_pop  = out_valid && out_ready;
  assign push_drop = done && fifo_full && !fifo_pop;

  fib_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (done),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky loss flag: a term arriving while busy or a result hitting a full FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                        overflow <= 1'b0;
    else if ((in_valid && state == ST_CONV) || push_drop) overflow <= 1'b1;
  end

  // Head fields are forced to zero when empty so the outputs are defined after reset.
  assign out_valid   = !fifo_empty;
  assign out_tens    = out_valid ? head[TENS_LSB +: DIGIT_W] : '0;
  assign out_ones    = out_valid ? head[ONES_LSB +: DIGIT_W] : '0;
  assign out_index   = out_valid ? head[INDEX_LSB +: CNT_W] : '0;
  assign out_restart = out_valid && head[RESTART_B];

endmodule

// File: tb/tb_fib_term_bcd.sv
// Self-checking bench for fib_term_bcd: a transaction-level model predicts
// the queue contents and flags every cycle; directed tests pin exact results.
module tb_fib_term_bcd;

  localparam int IN_W  = 6;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [IN_W-1:0]  term = '0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [3:0]       out_tens;
  logic [3:0]       out_ones;
  logic [CNT_W-1:0] out_index;
  logic             out_restart;
  logic             overflow;
  logic             busy;

  int checks = 0;
  int errors = 0;

  fib_term_bcd #(.IN_W(IN_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .term        (term),
    .in_valid    (in_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_tens    (out_tens),
    .out_ones    (out_ones),
    .out_index   (out_index),
    .out_restart (out_restart),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int pk(input int t, input int o, input int i, input int r);
    return r * 4096 + i * 256 + t * 16 + o;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    int val;
  } pend_t;

  int    cyc;
  int    last_acc;
  int    prev_t;
  int    cnt;
  bit    m_ovf;
  bit    m_busy;
  int    mq[$];
  pend_t pend[$];

  // Model advances once per edge from the input values the DUT samples.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc = 0; last_acc = -100; prev_t = 0; cnt = 0; m_ovf = 0; m_busy = 0;
      mq.delete(); pend.delete();
    end else begin
      int  qsize;
      bit  popping;
      cyc++;
      qsize   = mq.size();
      popping = (qsize > 0) && out_ready;
      if (popping) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (qsize == DEPTH && !popping) m_ovf = 1;
        else mq.push_back(pend[0].val);
        void'(pend.pop_front());
      end
      if (in_valid) begin
        if (cyc >= last_acc + IN_W + 1) begin
          int t, r, idx;
          pend_t p;
          t   = int'(term);
          r   = (t < prev_t) ? 1 : 0;
          idx = r ? 0 : cnt;
          cnt = (idx + 1) % (1 << CNT_W);
          prev_t = t;
          last_acc = cyc;
          p.due = cyc + IN_W;
          p.val = pk(t / 10, t % 10, idx, r);
          pend.push_back(p);
        end else begin
          m_ovf = 1;
        end
      end
      m_busy = (cyc >= last_acc) && (cyc <= last_acc + IN_W - 1);
    end
  end

  int log_q[$];

  // Every-cycle comparison against the model, and log of popped entries.
  always @(negedge clock) begin
    if (reset) begin
      check("out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
      check("busy", int'(busy), int'(m_busy));
      check("overflow", int'(overflow), int'(m_ovf));
      if (out_valid && mq.size() > 0)
        check("head", pk(out_tens, out_ones, out_index, out_restart), mq[0]);
      if (out_valid && out_ready)
        log_q.push_back(pk(out_tens, out_ones, out_index, out_restart));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input bit ready);
    reset = 1'b0; in_valid = 1'b0; out_ready = ready;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    log_q.delete();
  endtask

  task automatic send(input int t);
    @(negedge clock);
    term = IN_W'(t); in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_log(input string name, input int exp_q[$]);
    check({name, "_count"}, log_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < log_q.size()) check($sformatf("%s_%0d", name, i), log_q[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int exp_q[$];
    int t2[11] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    int t3[5]  = '{1, 2, 3, 5, 8};

    // Reset values, checked while reset is held.
    #3;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);

    // Test 1: single conversion of 13.
    do_reset(1'b1);
    send(13);
    check("t1_busy", int'(busy), 1);
    idle(10);
    exp_q = '{pk(1, 3, 0, 0)};
    check_log("t1", exp_q);
    check("t1_drained", int'(out_valid), 0);

    // Test 2: the sequence 0..55 with pops enabled.
    do_reset(1'b1);
    foreach (t2[i]) begin
      send(t2[i]);
      idle(6);
    end
    idle(10);
    exp_q = '{pk(0,0,0,0), pk(0,1,1,0), pk(0,1,2,0), pk(0,2,3,0), pk(0,3,4,0), pk(0,5,5,0),
              pk(0,8,6,0), pk(1,3,7,0), pk(2,1,8,0), pk(3,4,9,0), pk(5,5,10,0)};
    check_log("t2", exp_q);
    check("t2_overflow", int'(overflow), 0);

    // Test 3: consumer stalled, fifth result dropped.
    do_reset(1'b0);
    foreach (t3[i]) begin
      send(t3[i]);
      idle(6);
    end
    idle(4);
    check("t3_overflow", int'(overflow), 1);
    check("t3_full_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    idle(8);
    exp_q = '{pk(0,1,0,0), pk(0,2,1,0), pk(0,3,2,0), pk(0,5,3,0)};
    check_log("t3", exp_q);

    // Test 4: second term arrives while busy and is dropped.
    do_reset(1'b1);
    send(21);
    idle(2);
    send(34);
    idle(10);
    check("t4_overflow", int'(overflow), 1);
    send(34);
    idle(10);
    exp_q = '{pk(2,1,0,0), pk(3,4,1,0)};
    check_log("t4", exp_q);

    // Test 5: restart detection and index reset.
    do_reset(1'b1);
    send(55); idle(6);
    send(0);  idle(6);
    send(63); idle(10);
    exp_q = '{pk(5,5,0,0), pk(0,0,0,1), pk(6,3,1,0)};
    check_log("t5", exp_q);

    // Test 6: asynchronous reset during conversion with entries queued.
    do_reset(1'b0);
    send(1); idle(6);
    send(2); idle(6);
    send(3);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("t6_out_valid", int'(out_valid), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_overflow", int'(overflow), 0);
    check("t6_fields", pk(out_tens, out_ones, out_index, out_restart), 0);
    @(negedge clock);
    reset = 1'b1;
    out_ready = 1'b1;
    log_q.delete();
    send(8);
    idle(10);
    exp_q = '{pk(0,8,0,0)};
    check_log("t6", exp_q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_term_bcd.md
Name: fib_term_bcd

Overview:
Downstream consumer of the Fibonacci generator's 6-bit term output.
- Accepts one term per in_valid strobe.
- Converts the term to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Tags each result with a running term index and a sequence-restart flag.
- Buffers results in a small FIFO, drained over a valid/ready handshake by the display or checker stage.

Parameters:
IN_W, 6, width of incoming term (max value 2^IN_W-1 must fit two BCD digits; 6 → 63)
DEPTH, 4, FIFO entries (power of 2, ≥2)
CNT_W, 4, width of term index counter

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
term  in  IN_W  Fibonacci term from upstream generator
in_valid  in  1  one-cycle strobe: term is a new sequence element
out_valid  out  1  FIFO head holds a valid entry
out_ready  in  1  consumer accepts head this cycle
out_tens  out  4  BCD tens digit of head
out_ones  out  4  BCD ones digit of head
out_index  out  CNT_W  term index of head
out_restart  out  1  head term was smaller than previous accepted term
overflow  out  1  sticky: a term or result was dropped
busy  out  1  conversion engine active

Behaviour:
- Reset (reset=0, async): all outputs 0; FIFO empty; FSM IDLE; index counter 0; prev_term 0; overflow 0. Reset mid-conversion aborts it with no partial push.
- FSM states:
  - IDLE: in_valid=1 at edge k → load shift reg {8'h00, term}; iter=0; capture restart=(term<prev_term); capture index (0 if restart, else counter); counter ← captured index+1 (mod 2^CNT_W); prev_term ← term; go CONV.
  - CONV: each edge, every BCD nibble ≥5 gets +3, then whole reg shifts left 1; iter increments. At the IN_W-th CONV edge (edge k+IN_W), push {restart, index, tens, ones} to FIFO; go IDLE. No separate PUSH state.
- busy=1 exactly while in CONV.
- Input rules:
  - in_valid while busy → term ignored; counter and prev_term unchanged; overflow ← 1.
  - in_valid on the same edge the FSM returns to IDLE is also dropped.
  - Minimum accepted spacing is IN_W+1 cycles.
- Latency: in_valid edge k → out_valid high after edge k+IN_W when FIFO was empty (6 cycles at default).
- FIFO:
  - Pop occurs when out_valid & out_ready.
  - Push when full with no simultaneous pop → result dropped, overflow ← 1.
  - Push and pop on the same edge while full → both occur, no overflow.
  - Push and pop on the same edge while empty → impossible, since pop needs out_valid.
  - Pointers wrap modulo DEPTH. Head fields show entry at read pointer; don't-care when out_valid=0.
- Index counter wraps 2^CNT_W-1 → 0 silently.
- First term after reset: prev_term=0, so restart=0 and index=0.
- overflow clears only on reset.

Decomposition:
- Shared package/header fib_pkg: IN_W, CNT_W defaults; BCD digit width 4; FIFO entry field offsets (restart, index, tens, ones); FSM state encodings IDLE/CONV.
- One sub-module: fib_sync_fifo (parameterised width/depth, push/pop/full/empty, same-edge push+pop when full).
- Conversion FSM stays in top.

Test Plan:
1. Reset released, term=13 with in_valid pulse, out_ready=1 → busy for 6 cycles; out_valid after edge k+6 with tens=1, ones=3, index=0, restart=0; out_valid drops after pop.
2. Terms 0,1,1,2,3,5,8,13,21,34,55 spaced 8 cycles, out_ready=1 → 11 entries in order, indices 0..10, BCD 0/0…5/5, all restart=0, overflow=0.
3. out_ready=0, five terms (1,2,3,5,8) spaced 8 cycles → first four stored, 8 dropped, overflow=1. Then out_ready=1 → pops 1,2,3,5 with indices 0..3.
4. term=21 accepted, second in_valid (term=34) 3 cycles later → only 21 (tens 2, ones 1) emitted; overflow=1; next accepted term gets index 1.
5. Terms 55 then 0 then 63 → entries (5,5,idx0,rst0), (0,0,idx0,rst1), (6,3,idx1,rst0).
6. reset=0 asserted asynchronously at CONV iteration 3 with two entries queued → all outputs 0 immediately, FIFO empty. After release, term=8 → entry (0,8,idx0,rst0).
